// File: rtl/led_driver_pkg.sv
// Shared types and constants for the HUB75 LED panel driver.
package led_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH,
        ST_DISPLAY
    } state_t;

    localparam int MEM_R_DATA_WIDTH = 6;

    // Bit positions inside a mem_din word {b1,g1,r1,b0,g0,r0}
    localparam int DIN_R0 = 0;
    localparam int DIN_G0 = 1;
    localparam int DIN_B0 = 2;
    localparam int DIN_R1 = 3;
    localparam int DIN_G1 = 4;
    localparam int DIN_B1 = 5;

endpackage

// File: rtl/led_bcm_timer.sv
// Binary-code-modulation on-time timer: counts one bit-plane display
// window and reports blanking after the configured on-count elapses.
module led_bcm_timer #(
    parameter int TW = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TW-1:0] total,
    input  logic [TW-1:0] on_cnt,
    output logic          blank,
    output logic          done
);

    logic [TW-1:0] el;
    logic [TW-1:0] total_q;
    logic [TW-1:0] on_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            el      <= '0;
            total_q <= '0;
            on_q    <= '0;
        end else if (load) begin
            el      <= '0;
            total_q <= total;
            on_q    <= on_cnt;
        end else if (!done) begin
            el <= el + 1'b1;
        end
    end

    assign blank = (el >= on_q);
    // A zero-length window still finishes after one cycle
    assign done  = (({1'b0, el} + 1'b1) >= {1'b0, total_q});

endmodule

// File: rtl/led_driver.sv
// HUB75 LED matrix driver: shifts pixel-pair columns, latches a scan row and
// shows each bit plane for a BCM-weighted time. LED_DRIVER_DBL_BUF_EN enables
// frame-buffer toggling on mem_buffer.
module led_driver
    import led_driver_pkg::*;
#(
    parameter int N_ROWS_MAX     = 64,
    parameter int N_COLS_MAX     = 256,
    parameter int BITDEPTH_MAX   = 8,
    parameter int LSB_BLANK_MAX  = 100,
    parameter int CTRL_REG_WIDTH = 32,
    localparam int MEM_R_ADDR_WIDTH = $clog2(N_ROWS_MAX * N_COLS_MAX) - 1,
    localparam int MEM_BIT_WIDTH    = $clog2(BITDEPTH_MAX)
) (
    input  logic                        clk,
    input  logic                        ctrl_rst,
    input  logic                        ctrl_en,
    input  logic [CTRL_REG_WIDTH-1:0]   ctrl_n_rows,
    input  logic [CTRL_REG_WIDTH-1:0]   ctrl_n_cols,
    input  logic [CTRL_REG_WIDTH-1:0]   ctrl_bitdepth,
    input  logic [CTRL_REG_WIDTH-1:0]   ctrl_lsb_blank,
    input  logic [CTRL_REG_WIDTH-1:0]   ctrl_brightness,
    output logic                        mem_clk,
    output logic                        mem_en,
    output logic                        mem_buffer,
    output logic [MEM_R_ADDR_WIDTH-1:0] mem_addr,
    output logic [MEM_BIT_WIDTH-1:0]    mem_bit,
    input  logic [MEM_R_DATA_WIDTH-1:0] mem_din,
    output logic                        disp_clk,
    output logic                        disp_blank,
    output logic                        disp_latch,
    output logic [4:0]                  disp_addr,
    output logic                        disp_r0,
    output logic                        disp_g0,
    output logic                        disp_b0,
    output logic                        disp_r1,
    output logic                        disp_g1,
    output logic                        disp_b1,
    output logic                        irq_disp_sync
);

    localparam int RW  = $clog2(N_ROWS_MAX + 1);
    localparam int SRW = $clog2(N_ROWS_MAX);
    localparam int CW  = $clog2(N_COLS_MAX + 1);
    localparam int BDW = $clog2(BITDEPTH_MAX + 1);
    localparam int LW  = $clog2(LSB_BLANK_MAX + 1);
    localparam int TW  = $clog2((LSB_BLANK_MAX << (BITDEPTH_MAX - 1)) + 1);
    localparam int PW  = TW + BDW;

    state_t state, state_nx;

    logic [RW-1:0]  rows_c;
    logic [CW-1:0]  cols_c;
    logic [BDW-1:0] bd_c, bright_c;
    logic [LW-1:0]  lsb_c;
    logic           cfg_ok;

    logic [SRW-1:0] cfg_srows;
    logic [CW-1:0]  cfg_cols;
    logic [BDW-1:0] cfg_bd, cfg_bright;
    logic [LW-1:0]  cfg_lsb;

    logic [CW:0]              sc;
    logic                     lc;
    logic [SRW-1:0]           row;
    logic [MEM_BIT_WIDTH-1:0] plane;
    logic [5:0]               data_q, pix;
    logic                     irq_q, buf_q;

    logic          shift_last, last_plane, last_row, frame_wrap, frame_end, cfg_load;
    logic [TW-1:0] bcm_total, bcm_on;
    logic          bcm_load, bcm_blank, bcm_done;

    assign rows_c   = RW'((ctrl_n_rows > CTRL_REG_WIDTH'(N_ROWS_MAX)) ? CTRL_REG_WIDTH'(N_ROWS_MAX) : ctrl_n_rows);
    assign cols_c   = CW'((ctrl_n_cols > CTRL_REG_WIDTH'(N_COLS_MAX)) ? CTRL_REG_WIDTH'(N_COLS_MAX) : ctrl_n_cols);
    assign bd_c     = BDW'((ctrl_bitdepth > CTRL_REG_WIDTH'(BITDEPTH_MAX)) ? CTRL_REG_WIDTH'(BITDEPTH_MAX) : ctrl_bitdepth);
    assign bright_c = BDW'((ctrl_brightness > CTRL_REG_WIDTH'(BITDEPTH_MAX)) ? CTRL_REG_WIDTH'(BITDEPTH_MAX) : ctrl_brightness);
    assign lsb_c    = LW'((ctrl_lsb_blank > CTRL_REG_WIDTH'(LSB_BLANK_MAX)) ? CTRL_REG_WIDTH'(LSB_BLANK_MAX) : ctrl_lsb_blank);
    assign cfg_ok   = (rows_c >= RW'(2)) && (cols_c != '0) && (bd_c != '0);

    assign shift_last = (sc == {cfg_cols, 1'b0});
    assign last_plane = (BDW'(plane) == cfg_bd - 1'b1);
    assign last_row   = (row == cfg_srows - 1'b1);
    assign frame_wrap = last_plane && last_row;
    assign frame_end  = (state == ST_DISPLAY) && bcm_done && frame_wrap && ctrl_en;
    assign cfg_load   = (state == ST_IDLE) || ((state == ST_DISPLAY) && bcm_done && frame_wrap);

    assign bcm_load  = (state == ST_LATCH) && lc;
    assign bcm_total = TW'(cfg_lsb) << plane;

    always_comb begin
        bcm_on = '0;
        if (cfg_bright < BDW'(BITDEPTH_MAX))
            bcm_on = TW'((PW'(bcm_total) * PW'(BDW'(BITDEPTH_MAX) - cfg_bright)) / PW'(BITDEPTH_MAX));
    end

    led_bcm_timer #(.TW(TW)) u_bcm (
        .clk    (clk),
        .rst    (ctrl_rst),
        .load   (bcm_load),
        .total  (bcm_total),
        .on_cnt (bcm_on),
        .blank  (bcm_blank),
        .done   (bcm_done)
    );

    always_ff @(posedge clk) begin
        if (ctrl_rst) state <= ST_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (cfg_ok) state_nx = ST_SHIFT;
            ST_SHIFT:   if (shift_last) state_nx = ST_LATCH;
            ST_LATCH:   if (lc) state_nx = ST_DISPLAY;
            ST_DISPLAY: if (bcm_done) state_nx = (frame_wrap && !cfg_ok) ? ST_IDLE : ST_SHIFT;
            default:    state_nx = ST_IDLE;
        endcase
        if (!ctrl_en) state_nx = ST_IDLE;
    end

    always_comb begin
        disp_blank = 1'b1;
        disp_latch = 1'b0;
        disp_clk   = 1'b0;
        mem_en     = 1'b0;
        pix        = '0;
        case (state)
            ST_SHIFT: begin
                mem_en   = !sc[0] && !shift_last;
                disp_clk = !sc[0] && (sc != '0);
                // Odd cycles present fresh memory data, even cycles hold it under the rising clock
                pix      = sc[0] ? mem_din : data_q;
            end
            ST_LATCH:   disp_latch = 1'b1;
            ST_DISPLAY: disp_blank = bcm_blank;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ctrl_rst) begin
            cfg_srows  <= '0;
            cfg_cols   <= '0;
            cfg_bd     <= '0;
            cfg_lsb    <= '0;
            cfg_bright <= '0;
            sc         <= '0;
            lc         <= 1'b0;
            row        <= '0;
            plane      <= '0;
            data_q     <= '0;
            disp_addr  <= '0;
            irq_q      <= 1'b0;
        end else begin
            irq_q <= frame_end;
            if (cfg_load) begin
                cfg_srows  <= SRW'(rows_c >> 1);
                cfg_cols   <= cols_c;
                cfg_bd     <= bd_c;
                cfg_lsb    <= lsb_c;
                cfg_bright <= bright_c;
            end
            case (state)
                ST_IDLE: begin
                    sc    <= '0;
                    lc    <= 1'b0;
                    row   <= '0;
                    plane <= '0;
                end
                ST_SHIFT: begin
                    if (sc[0]) data_q <= mem_din;
                    if (shift_last) begin
                        sc        <= '0;
                        disp_addr <= 5'(row);
                    end else begin
                        sc <= sc + 1'b1;
                    end
                end
                ST_LATCH: lc <= ~lc;
                ST_DISPLAY: if (bcm_done) begin
                    if (!last_plane) begin
                        plane <= plane + 1'b1;
                    end else begin
                        plane <= '0;
                        row   <= last_row ? '0 : row + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LED_DRIVER_DBL_BUF_EN
    always_ff @(posedge clk) begin
        if (ctrl_rst)       buf_q <= 1'b0;
        else if (frame_end) buf_q <= ~buf_q;
    end
`else
    assign buf_q = 1'b0;
`endif

    assign mem_clk       = clk;
    assign mem_buffer    = buf_q;
    assign mem_addr      = MEM_R_ADDR_WIDTH'(32'(row) * 32'(cfg_cols) + 32'(sc[CW:1]));
    assign mem_bit       = plane;
    assign irq_disp_sync = irq_q;
    assign disp_r0       = pix[DIN_R0];
    assign disp_g0       = pix[DIN_G0];
    assign disp_b0       = pix[DIN_B0];
    assign disp_r1       = pix[DIN_R1];
    assign disp_g1       = pix[DIN_G1];
    assign disp_b1       = pix[DIN_B1];

endmodule

// File: tb/tb_led_driver.sv
// Directed bench for led_driver: frame timing, shifted data, BCM widths,
// reset/enable aborts and configuration boundaries.
module tb_led_driver;

    logic        clk = 1'b0;
    logic        ctrl_rst = 1'b1, ctrl_en = 1'b0;
    logic [31:0] ctrl_n_rows = 0, ctrl_n_cols = 0, ctrl_bitdepth = 0, ctrl_lsb_blank = 0, ctrl_brightness = 0;
    logic        mem_clk, mem_en, mem_buffer;
    logic [12:0] mem_addr;
    logic [2:0]  mem_bit;
    logic [5:0]  mem_din = '0;
    logic        disp_clk, disp_blank, disp_latch;
    logic [4:0]  disp_addr;
    logic        disp_r0, disp_g0, disp_b0, disp_r1, disp_g1, disp_b1;
    logic        irq_disp_sync;

    int n_tests = 0, n_fail = 0;

    led_driver dut (
        .clk(clk), .ctrl_rst(ctrl_rst), .ctrl_en(ctrl_en),
        .ctrl_n_rows(ctrl_n_rows), .ctrl_n_cols(ctrl_n_cols), .ctrl_bitdepth(ctrl_bitdepth),
        .ctrl_lsb_blank(ctrl_lsb_blank), .ctrl_brightness(ctrl_brightness),
        .mem_clk(mem_clk), .mem_en(mem_en), .mem_buffer(mem_buffer), .mem_addr(mem_addr),
        .mem_bit(mem_bit), .mem_din(mem_din),
        .disp_clk(disp_clk), .disp_blank(disp_blank), .disp_latch(disp_latch), .disp_addr(disp_addr),
        .disp_r0(disp_r0), .disp_g0(disp_g0), .disp_b0(disp_b0),
        .disp_r1(disp_r1), .disp_g1(disp_g1), .disp_b1(disp_b1),
        .irq_disp_sync(irq_disp_sync)
    );

    always #5 clk = ~clk;

    // Synchronous memory returning the low address bits
    always @(posedge clk) if (mem_en) mem_din <= mem_addr[5:0];

    int   cyc, run_len, edges, en_cnt;
    logic prev_clk, prev_latch;
    int   irq_t[$], runs[$], edge_q[$], addr_q[$], pix_q[$];

    always @(negedge clk) begin
        cyc++;
        if (irq_disp_sync) irq_t.push_back(cyc);
        if (mem_en) en_cnt++;
        if (!disp_blank) run_len++;
        else if (run_len != 0) begin runs.push_back(run_len); run_len = 0; end
        if (disp_clk && !prev_clk) begin
            edges++;
            pix_q.push_back({29'd0, disp_r0, disp_g0, disp_b0, disp_r1, disp_g1, disp_b1});
        end
        if (disp_latch && !prev_latch) begin
            edge_q.push_back(edges);
            addr_q.push_back(int'(disp_addr));
            edges = 0;
        end
        prev_clk   = disp_clk;
        prev_latch = disp_latch;
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_start(input int rows, input int cols, input int bd, input int lsb, input int br);
        ctrl_rst = 1'b1;
        ctrl_en  = 1'b1;
        ctrl_n_rows = rows; ctrl_n_cols = cols; ctrl_bitdepth = bd;
        ctrl_lsb_blank = lsb; ctrl_brightness = br;
        run(3);
        irq_t.delete(); runs.delete(); edge_q.delete(); addr_q.delete(); pix_q.delete();
        cyc = 0; run_len = 0; edges = 0; en_cnt = 0;
        ctrl_rst = 1'b0;
    endtask

    task automatic chk_period(input string tag, input int exp);
        chk({tag, "_n"}, (irq_t.size() >= 2) ? 1 : 0, 1);
        for (int i = 1; i < irq_t.size(); i++) chk(tag, irq_t[i] - irq_t[i-1], exp);
    endtask

    initial begin
        int errs, found, n_irq;
        int exp1[4];
        int exp2[4];
        exp1 = '{6, 12, 24, 48};
        exp2 = '{3, 6, 12, 24};

        // Reset state with enable already high: reset wins
        ctrl_en = 1'b1;
        ctrl_n_rows = 20; ctrl_n_cols = 8; ctrl_bitdepth = 4; ctrl_lsb_blank = 6;
        run(3);
        chk("rst_blank", int'(disp_blank), 1);
        chk("rst_latch", int'(disp_latch), 0);
        chk("rst_dclk", int'(disp_clk), 0);
        chk("rst_mem_en", int'(mem_en), 0);
        chk("rst_buf", int'(mem_buffer), 0);
        chk("rst_irq", int'(irq_disp_sync), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_daddr", int'(disp_addr), 0);

        // Main configuration
        cfg_start(20, 8, 4, 6, 0);
        run(5000);
        chk("irq_count", irq_t.size(), 3);
        chk_period("irq_period", 1660);
        chk("latch_count", (edge_q.size() >= 41) ? 1 : 0, 1);
        errs = 0;
        for (int i = 0; i < 40 && i < edge_q.size(); i++) if (edge_q[i] != 8) errs++;
        chk("edges_per_plane", errs, 0);
        errs = 0;
        for (int i = 0; i < 40 && i < addr_q.size(); i++) if (addr_q[i] != i / 4) errs++;
        chk("disp_addr_seq", errs, 0);
        if (addr_q.size() > 40) chk("disp_addr_wrap", addr_q[40], 0);
        chk("pix_count", (pix_q.size() >= 320) ? 1 : 0, 1);
        if (pix_q.size() >= 320) begin
            chk("pix_r0c0", pix_q[0], 6'b000000);
            chk("pix_r1c3", pix_q[35], 6'b110100);
            chk("pix_r2c7", pix_q[71], 6'b111010);
            chk("pix_r9p3c7", pix_q[319], 6'b111100);
        end
        chk("run_count", (runs.size() >= 4) ? 1 : 0, 1);
        for (int i = 0; i < 4 && i < runs.size(); i++) chk("blank_low_b0", runs[i], exp1[i]);
`ifdef LED_DRIVER_DBL_BUF_EN
        chk("buf_parity", int'(mem_buffer), irq_t.size() % 2);
`else
        chk("buf_const", int'(mem_buffer), 0);
`endif

        // Reduced brightness
        cfg_start(20, 8, 4, 6, 4);
        run(3400);
        chk("run_count_b4", (runs.size() >= 4) ? 1 : 0, 1);
        for (int i = 0; i < 4 && i < runs.size(); i++) chk("blank_low_b4", runs[i], exp2[i]);
        chk_period("irq_period_b4", 1660);

        // Reset asserted mid-DISPLAY
        found = 0;
        for (int i = 0; i < 4000 && found == 0; i++) begin
            run(1);
            if (!disp_blank) found = 1;
        end
        chk("wait_display", found, 1);
        n_irq = irq_t.size();
        ctrl_rst = 1'b1;
        run(1);
        chk("midrst_blank", int'(disp_blank), 1);
        chk("midrst_latch", int'(disp_latch), 0);
        chk("midrst_irq", int'(irq_disp_sync), 0);
        run(20);
        chk("midrst_no_irq", irq_t.size(), n_irq);
        chk("midrst_buf", int'(mem_buffer), 0);

        // Enable dropped during SHIFT
        cfg_start(20, 8, 4, 6, 0);
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            run(1);
            if (disp_clk) found = 1;
        end
        chk("wait_shift", found, 1);
        ctrl_en = 1'b0;
        run(1);
        chk("enoff_blank", int'(disp_blank), 1);
        chk("enoff_dclk", int'(disp_clk), 0);
        chk("enoff_mem_en", int'(mem_en), 0);

        // Invalid configurations stay idle
        cfg_start(1, 8, 4, 6, 0);
        run(300);
        chk("idle_rows1", en_cnt + edges + edge_q.size(), 0);
        cfg_start(20, 0, 4, 6, 0);
        run(300);
        chk("idle_cols0", en_cnt + edges + edge_q.size(), 0);
        cfg_start(20, 8, 0, 6, 0);
        run(300);
        chk("idle_bd0", en_cnt + edges + edge_q.size(), 0);

        // Bitdepth clamped to 8: period 8*(3+2) + 255 = 295
        cfg_start(2, 1, 20, 1, 0);
        run(700);
        chk_period("irq_period_clamp", 295);
        chk("run_count_clamp", (runs.size() >= 8) ? 1 : 0, 1);
        for (int i = 0; i < 8 && i < runs.size(); i++) chk("blank_low_clamp", runs[i], 1 << i);

        // Brightness beyond max blanks fully
        cfg_start(2, 1, 20, 1, 9);
        run(700);
        chk("full_blank_runs", runs.size() + run_len, 0);
        chk_period("irq_period_dark", 295);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
